// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run-time divisor/start/stop controller for the registered clock divider
// Divisor changes and stops take effect only at a period boundary, so clk_out never has a runt.
module clk_div_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 5
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             running,
   output logic [CNT_W-1:0] cur_div
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] pend_div, pend_nxt;
   logic [CNT_W-1:0] div_nxt;
   logic [CNT_W:0]   half_nxt;
   logic             clk_nxt, tick_nxt, err_nxt;
   logic             xfer, legal, last;

   assign cfg_ready = (state != PEND);
   assign running   = (state != IDLE);
   assign xfer      = cfg_valid & cfg_ready;
   assign legal     = (cfg_div > CNT_W'(1));
   assign last      = (cnt == cur_div - CNT_W'(1));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pend_nxt  = pend_div;
      div_nxt   = cur_div;
      err_nxt   = xfer & ~legal;
      clk_nxt   = 1'b0;
      tick_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (xfer && legal) div_nxt = cfg_div;
            if (en) state_nxt = RUN;
         end
         RUN: begin
            if (last) begin
               cnt_nxt = '0;
               // Stopping with a fresh divisor on the boundary: IDLE would accept it anyway.
               if (!en) begin
                  state_nxt = IDLE;
                  if (xfer && legal) div_nxt = cfg_div;
               end else if (xfer && legal) begin
                  state_nxt = PEND;
                  pend_nxt  = cfg_div;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
               if (xfer && legal) begin
                  state_nxt = PEND;
                  pend_nxt  = cfg_div;
               end
            end
         end
         PEND: begin
            if (last) begin
               cnt_nxt   = '0;
               div_nxt   = pend_div;
               state_nxt = en ? RUN : IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Waveform is decoded from next-cycle count/divisor so clk_out and tick are registered.
      half_nxt = ({1'b0, div_nxt} + (CNT_W+1)'(1)) >> 1;
      if (state_nxt != IDLE) begin
         clk_nxt  = ({1'b0, cnt_nxt} < half_nxt);
         tick_nxt = (cnt_nxt == '0);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pend_div <= CNT_W'(DEF_DIV);
         cur_div  <= CNT_W'(DEF_DIV);
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pend_div <= pend_nxt;
         cur_div  <= div_nxt;
         clk_out  <= clk_nxt;
         tick     <= tick_nxt;
         cfg_err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - table-driven and hand-sequenced checks of clk_div_ctrl
module tb_clk_div_ctrl;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_div = 8'd0;
   logic       cfg_ready, cfg_err, clk_out, tick, running;
   logic [7:0] cur_div;

   int n_cmp  = 0;
   int n_fail = 0;

   clk_div_ctrl #(.CNT_W(8), .DEF_DIV(5)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .running   (running),
      .cur_div   (cur_div)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit       r;
      bit       e;
      bit       v;
      bit [7:0] d;
      bit [12:0] exp;   // {clk_out, tick, cfg_ready, cfg_err, running, cur_div}
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit r, bit e, bit v, bit [7:0] d,
                               bit ck, bit tk, bit rd, bit er, bit rn, bit [7:0] cd);
      vec_t t;
      t.r = r; t.e = e; t.v = v; t.d = d;
      t.exp = {ck, tk, rd, er, rn, cd};
      vecs.push_back(t);
   endfunction

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic run_pattern(int d);
      int errs, ticks;
      errs = 0;
      ticks = 0;
      cfg_valid = 1'b1; cfg_div = 8'(d); en = 1'b0;
      step();
      chk($sformatf("load D=%0d", d), cur_div, d);
      cfg_valid = 1'b0; en = 1'b1;
      step();
      for (int i = 0; i < 2 * d; i++) begin
         if (clk_out !== (((i % d) < ((d + 1) / 2)) ? 1'b1 : 1'b0)) errs++;
         if (tick === 1'b1) ticks++;
         if (tick !== (((i % d) == 0) ? 1'b1 : 1'b0)) errs++;
         step();
      end
      chk($sformatf("D=%0d waveform errors", d), errs, 0);
      chk($sformatf("D=%0d tick count", d), ticks, 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      logic [12:0] act;

      //   r  e  v  d     clk tk rdy err run div
      add(1, 0, 0, 0,    0, 0, 1, 0, 0, 5);   // reset
      add(0, 0, 0, 0,    0, 0, 1, 0, 0, 5);
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 5);   // start, cnt0
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 5);   // cnt0
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 5);   // cnt1
      add(0, 1, 1, 1,    1, 0, 1, 1, 1, 5);   // illegal div=1 -> err
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 5);
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 5);   // cnt1
      add(0, 1, 1, 4,    1, 0, 0, 0, 1, 5);   // div=4 at cnt1 -> PEND
      add(0, 1, 0, 0,    0, 0, 0, 0, 1, 5);
      add(0, 1, 0, 0,    0, 0, 0, 0, 1, 5);
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 4);   // boundary applies 4
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 4);
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 4);
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 4);
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 4);
      add(0, 1, 1, 5,    1, 0, 0, 0, 1, 4);   // back to 5
      add(0, 1, 0, 0,    0, 0, 0, 0, 1, 4);
      add(0, 1, 0, 0,    0, 0, 0, 0, 1, 4);
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 5);
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 5);   // cnt2
      add(0, 0, 0, 0,    0, 0, 1, 0, 1, 5);   // en low mid-period ignored
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 5);
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 5);
      add(0, 0, 0, 0,    1, 0, 1, 0, 1, 5);   // en held low from here
      add(0, 0, 0, 0,    1, 0, 1, 0, 1, 5);
      add(0, 0, 0, 0,    0, 0, 1, 0, 1, 5);
      add(0, 0, 0, 0,    0, 0, 1, 0, 1, 5);
      add(0, 0, 0, 0,    0, 0, 1, 0, 0, 5);   // stopped at boundary
      add(0, 0, 1, 4,    0, 0, 1, 0, 0, 4);   // IDLE update
      add(0, 1, 0, 0,    1, 1, 1, 0, 1, 4);
      add(0, 1, 0, 0,    1, 0, 1, 0, 1, 4);
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 4);
      add(0, 1, 0, 0,    0, 0, 1, 0, 1, 4);   // cnt3
      add(1, 1, 0, 0,    0, 0, 1, 0, 0, 5);   // reset mid-period
      add(0, 0, 0, 0,    0, 0, 1, 0, 0, 5);

      foreach (vecs[i]) begin
         rst = vecs[i].r; en = vecs[i].e; cfg_valid = vecs[i].v; cfg_div = vecs[i].d;
         step();
         act = {clk_out, tick, cfg_ready, cfg_err, running, cur_div};
         chk($sformatf("vec%0d", i), act, vecs[i].exp);
      end
      cfg_valid = 1'b0;

      run_pattern(255);
      en = 1'b0;
      waited = 0;
      while (running !== 1'b0 && waited < 300) begin
         step();
         waited++;
      end
      chk("D=255 stop reached", (waited < 300) ? 1 : 0, 1);
      chk("D=255 clk_out after stop", clk_out, 0);

      run_pattern(2);
      step();                              // cnt1: boundary cycle for D=2
      cfg_valid = 1'b1; cfg_div = 8'd3;
      step();
      cfg_valid = 1'b0;
      chk("boundary xfer div held", {cfg_ready, tick, cur_div}, {1'b0, 1'b1, 8'd2});
      step();
      chk("boundary xfer old period", {cfg_ready, clk_out, cur_div}, {1'b0, 1'b0, 8'd2});
      step();
      chk("boundary xfer applied", {cfg_ready, tick, clk_out, cur_div}, {1'b1, 1'b1, 1'b1, 8'd3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
